// File: rtl/render_output_collector.sv
// Frame sink for the 512-bit result stream: drains an ap_fifo read port under ap_start/ap_done control.
// Optional checksum accumulation is enabled with `define RENDER_COLLECTOR_CHECKSUM_EN.
module render_output_collector #(
  parameter int DATA_WIDTH     = 512,
  parameter int OUTPUT_SIZE    = 1024,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  empty_n,
  output logic                  read,
  input  logic                  sink_en,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [DATA_WIDTH-1:0] last_word,
  output logic                  timeout
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(OUTPUT_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] WD_MAX   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] wdog;

  // read is combinational so the async reset (state -> IDLE) drops it at once
  assign read     = (state == S_RUN) & empty_n & sink_en;
  assign ap_ready = ap_done;

`ifdef RENDER_COLLECTOR_CHECKSUM_EN
  logic [31:0] fold;
  always_comb begin
    fold = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) fold = fold ^ din[i*32 +: 32];
  end
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      timeout   <= 1'b0;
      word_cnt  <= '0;
      cycle_cnt <= '0;
      last_word <= '0;
      wdog      <= '0;
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state     <= S_RUN;
            ap_idle   <= 1'b0;
            word_cnt  <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            wdog      <= '0;
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
        S_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (read) begin
            // a consume always clears the watchdog, so it beats a same-cycle timeout
            word_cnt  <= word_cnt + 1'b1;
            last_word <= din;
            wdog      <= '0;
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
            checksum  <= {checksum[30:0], checksum[31]} ^ fold;
`endif
            if (word_cnt == LAST_IDX) begin
              state   <= S_DONE;
              ap_done <= 1'b1;
            end
          end else if (!empty_n) begin
            if (wdog == WD_MAX) begin
              state   <= S_DONE;
              ap_done <= 1'b1;
              timeout <= 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_output_collector.sv
// Bench for render_output_collector: directed frame table, reset/restart sequences, random frames vs a count-based model.
module tb_render_output_collector;
  localparam int DW = 64;
  localparam int OS = 4;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start, ap_done, ap_idle, ap_ready;
  logic [DW-1:0] din;
  logic          empty_n, read, sink_en;
  logic [CW-1:0] word_cnt, cycle_cnt;
  logic [DW-1:0] last_word;
  logic          timeout;
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  render_output_collector #(.DATA_WIDTH(DW), .OUTPUT_SIZE(OS), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .din(din), .empty_n(empty_n), .read(read), .sink_en(sink_en),
    .word_cnt(word_cnt), .cycle_cnt(cycle_cnt), .last_word(last_word), .timeout(timeout)
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference state carried across frames
  logic [DW-1:0] m_last;
  logic [31:0]   m_chk;
  int            rnd_pe;

  typedef struct {
    int mode;   // 0 stream, 1 sink toggle, 2 starve, 3 starve/word/starve, 5 start held high
    int words;
    int cycles;
    bit to;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [DW-1:0] d);
    logic [31:0] f = '0;
    for (int i = 0; i < DW / 32; i++) f = f ^ d[i*32 +: 32];
    return f;
  endfunction

  task automatic run_frame(input int mode, input bit use_tbl, input int ew, input int ec, input bit eto);
    int words = 0, cyc = 0, wd = 0, k;
    bit to = 0, done = 0, en, sk, er;
    logic [DW-1:0] d;
    @(posedge clk); #1;
    ap_start = 1'b1; empty_n = 1'b0; sink_en = 1'b0; din = '0;
    @(negedge clk);
    chk("idle_before_start", ap_idle, 1'b1);
    @(posedge clk); #1;
    ap_start = (mode == 5);
    m_chk = '0;
    for (k = 1; k <= 200 && !done; k++) begin
      case (mode)
        1:       begin en = 1'b1; sk = k[0]; end
        2:       begin en = 1'b0; sk = 1'b1; end
        3:       begin en = (k == 8) || (k >= 16); sk = 1'b1; end
        4:       begin en = $urandom_range(0, 99) < rnd_pe; sk = $urandom_range(0, 3) != 0; end
        default: begin en = 1'b1; sk = 1'b1; end
      endcase
      d = (mode == 4) ? {$urandom, $urandom} : DW'(words + 1);
      empty_n = en; sink_en = sk; din = d;
      @(negedge clk);
      if (k == 1) begin
        chk("cleared_word_cnt", word_cnt, '0);
        chk("cleared_cycle_cnt", cycle_cnt, '0);
        chk("cleared_timeout", timeout, 1'b0);
      end
      er = en & sk;
      chk("read_run", read, er);
      chk("done_low_in_run", ap_done, 1'b0);
      cyc++;
      if (er) begin
        words++; m_last = d; m_chk = {m_chk[30:0], m_chk[31]} ^ fold(d); wd = 0;
        if (words == OS) done = 1;
      end else if (!en) begin
        if (wd == TO - 1) begin to = 1; done = 1; end
        else wd++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++;
      $display("FAIL frame_bound: got no end after %0d cycles expected end", k - 1);
    end
    // DONE cycle: data offered but must not be consumed
    ap_start = (mode == 5); empty_n = 1'b1; sink_en = 1'b1;
    @(negedge clk);
    chk("done_pulse", ap_done, 1'b1);
    chk("ready_pulse", ap_ready, 1'b1);
    chk("read_in_done", read, 1'b0);
    chk("word_cnt", word_cnt, DW'(words));
    chk("cycle_cnt", cycle_cnt, DW'(cyc));
    chk("timeout", timeout, to);
    chk("last_word", last_word, m_last);
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
    chk("checksum", checksum, m_chk);
`endif
    if (use_tbl) begin
      chk("tbl_word_cnt", word_cnt, DW'(ew));
      chk("tbl_cycle_cnt", cycle_cnt, DW'(ec));
      chk("tbl_timeout", timeout, eto);
    end
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", ap_idle, 1'b1);
    chk("done_one_cycle", ap_done, 1'b0);
    chk("read_in_idle", read, 1'b0);
    chk("held_word_cnt", word_cnt, DW'(words));
    chk("held_cycle_cnt", cycle_cnt, DW'(cyc));
  endtask

  initial begin
    tbl[0] = '{mode: 0, words: 4, cycles: 4,  to: 1'b0};
    tbl[1] = '{mode: 1, words: 4, cycles: 7,  to: 1'b0};
    tbl[2] = '{mode: 2, words: 0, cycles: 8,  to: 1'b1};
    tbl[3] = '{mode: 3, words: 4, cycles: 18, to: 1'b0};
    tbl[4] = '{mode: 5, words: 4, cycles: 4,  to: 1'b0};

    rst_n = 1'b0; ap_start = 1'b0; empty_n = 1'b0; sink_en = 1'b0; din = '0;
    m_last = '0; m_chk = '0; rnd_pe = 50;
    #12;
    chk("rst_idle", ap_idle, 1'b1);
    chk("rst_done", ap_done, 1'b0);
    chk("rst_ready", ap_ready, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_word_cnt", word_cnt, '0);
    chk("rst_cycle_cnt", cycle_cnt, '0);
    chk("rst_last_word", last_word, '0);
    chk("rst_timeout", timeout, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(tbl[i].mode, 1'b1, tbl[i].words, tbl[i].cycles, tbl[i].to);

    // known checksum for the 1,2,3,4 stream
    run_frame(0, 1'b1, 4, 4, 1'b0);
`ifdef RENDER_COLLECTOR_CHECKSUM_EN
    chk("checksum_1234", checksum, 32'h0000_0002);
`endif

    // mid-frame reset after two words
    @(posedge clk); #1;
    ap_start = 1'b1; empty_n = 1'b1; sink_en = 1'b1; din = 64'h11;
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(posedge clk); #1 din = 64'h22;
    @(posedge clk); #1 din = 64'h33;
    #1 chk("pre_rst_read", read, 1'b1);
    chk("pre_rst_word_cnt", word_cnt, DW'(2));
    rst_n = 1'b0;
    #1;
    chk("async_rst_read", read, 1'b0);
    chk("async_rst_idle", ap_idle, 1'b1);
    chk("async_rst_word_cnt", word_cnt, '0);
    chk("async_rst_cycle_cnt", cycle_cnt, '0);
    chk("async_rst_last_word", last_word, '0);
    chk("async_rst_done", ap_done, 1'b0);
    m_last = '0;
    @(negedge clk); rst_n = 1'b1;
    run_frame(0, 1'b1, 4, 4, 1'b0);

    // random frames
    for (int f = 0; f < 40; f++) begin
      rnd_pe = (f % 4 == 0) ? 30 : 70 + (f % 3) * 10;
      run_frame(4, 1'b0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
